// File: rtl/miner_pkg.sv
// Shared definitions for the nonce dispatcher: FSM encoding, result frame layout
// and default miner timing.
package miner_pkg;

    localparam int unsigned NONCE_W                  = 32;
    localparam int unsigned HASH_W                   = 256;
    localparam int unsigned BYTE_W                   = 8;
    localparam int unsigned RESULT_BYTES             = 36;
    localparam int unsigned RESULT_W                 = RESULT_BYTES * BYTE_W;
    localparam int unsigned BYTE_IDX_W               = 6;
    localparam int unsigned FOUND_W                  = 16;
    localparam int unsigned CYCLES_PER_NONCE_DEFAULT = 198;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Result frame in transmit order: nonce bytes first, then hash, both MSB first.
    typedef struct packed {
        logic [NONCE_W-1:0] nonce;
        logic [HASH_W-1:0]  hash;
    } result_t;

    function automatic logic [FOUND_W-1:0] sat_inc(input logic [FOUND_W-1:0] value);
        return (value == '1) ? value : value + FOUND_W'(1);
    endfunction

endpackage

// File: rtl/result_serializer.sv
// Streams a 36-byte result frame over a valid/ready byte interface, MSB byte first.
module result_serializer
    import miner_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [RESULT_W-1:0] payload,
    input  logic                tx_ready,
    output logic [BYTE_W-1:0]   tx_data,
    output logic                tx_valid,
    output logic                last_c
);

    logic [RESULT_W-1:0]   shreg;
    logic [RESULT_W-1:0]   shreg_next;
    logic [BYTE_IDX_W-1:0] idx;
    logic [BYTE_IDX_W-1:0] idx_next;
    logic                  valid_next;
    logic                  fire_c;

    assign fire_c  = tx_valid & tx_ready;
    assign last_c  = fire_c && (idx == BYTE_IDX_W'(RESULT_BYTES - 1));
    // Current byte always sits at the top of the shift register, so it holds while stalled.
    assign tx_data = shreg[RESULT_W-1 -: BYTE_W];

    always_comb begin
        shreg_next = shreg;
        idx_next   = idx;
        valid_next = tx_valid;
        if (load) begin
            shreg_next = payload;
            idx_next   = '0;
            valid_next = 1'b1;
        end else if (fire_c) begin
            shreg_next = {shreg[RESULT_W-BYTE_W-1:0], BYTE_W'(0)};
            if (last_c) begin
                idx_next   = '0;
                valid_next = 1'b0;
            end else begin
                idx_next = idx + BYTE_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            shreg    <= '0;
            idx      <= '0;
            tx_valid <= 1'b0;
        end else begin
            shreg    <= shreg_next;
            idx      <= idx_next;
            tx_valid <= valid_next;
        end
    end

endmodule

// File: rtl/nonce_dispatcher.sv
// Sweeps nonces across a miner core, restarting it per nonce, and reports each
// successful nonce plus its hash as a 36-byte frame.
module nonce_dispatcher
    import miner_pkg::*;
#(
    parameter int unsigned CYCLES_PER_NONCE = CYCLES_PER_NONCE_DEFAULT,
    parameter logic [31:0] NONCE_START      = 32'h0000_0000,
    parameter logic [31:0] NONCE_END        = 32'hFFFF_FFFF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    output logic [NONCE_W-1:0] nonce,
    output logic               miner_reset,
    input  logic               hash_success,
    input  logic [HASH_W-1:0]  hash_in,
    output logic [BYTE_W-1:0]  tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               exhausted,
    output logic [FOUND_W-1:0] found_count
);

    localparam int unsigned CNT_W = (CYCLES_PER_NONCE > 1) ? $clog2(CYCLES_PER_NONCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_NONCE - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [NONCE_W-1:0] nonce_next;
    logic               miner_reset_next;
    logic [FOUND_W-1:0] found_next;
    logic               stop_seen;
    logic               stop_seen_next;
    logic               busy_next;
    logic               exhausted_next;
    logic               load_c;
    logic               last_c;
    result_t            result_c;

    always_comb begin
        result_c.nonce = nonce;
        result_c.hash  = hash_in;
    end

    result_serializer u_serializer (
        .clock    (clock),
        .reset    (reset),
        .load     (load_c),
        .payload  (result_c),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .last_c   (last_c)
    );

    // Next-state and datapath updates; stop outranks success, success outranks terminal count.
    always_comb begin
        state_next       = state;
        nonce_next       = nonce;
        cnt_next         = cnt;
        miner_reset_next = 1'b0;
        found_next       = found_count;
        stop_seen_next   = stop_seen;
        load_c           = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start && !stop) begin
                    nonce_next       = NONCE_START;
                    cnt_next         = '0;
                    miner_reset_next = 1'b1;
                    stop_seen_next   = 1'b0;
                    state_next       = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else if (hash_success && !miner_reset) begin
                    load_c         = 1'b1;
                    found_next     = sat_inc(found_count);
                    stop_seen_next = 1'b0;
                    state_next     = ST_REPORT;
                end else if (cnt == CNT_LAST) begin
                    if (nonce == NONCE_END) begin
                        state_next = ST_DONE;
                    end else begin
                        nonce_next       = nonce + NONCE_W'(1);
                        cnt_next         = '0;
                        miner_reset_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_REPORT: begin
                stop_seen_next = stop_seen | stop;
                if (last_c) begin
                    stop_seen_next = 1'b0;
                    if (stop_seen || stop) begin
                        state_next = ST_IDLE;
                    end else if (nonce == NONCE_END) begin
                        state_next = ST_DONE;
                    end else begin
                        nonce_next       = nonce + NONCE_W'(1);
                        cnt_next         = '0;
                        miner_reset_next = 1'b1;
                        state_next       = ST_RUN;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next      = (state_next == ST_RUN) || (state_next == ST_REPORT);
        exhausted_next = (state_next == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_IDLE;
            nonce       <= NONCE_START;
            cnt         <= '0;
            miner_reset <= 1'b0;
            found_count <= '0;
            stop_seen   <= 1'b0;
            busy        <= 1'b0;
            exhausted   <= 1'b0;
        end else begin
            state       <= state_next;
            nonce       <= nonce_next;
            cnt         <= cnt_next;
            miner_reset <= miner_reset_next;
            found_count <= found_next;
            stop_seen   <= stop_seen_next;
            busy        <= busy_next;
            exhausted   <= exhausted_next;
        end
    end

endmodule
